filt_fir_seq_ctrl: RTL and testbench

- Scheduler for a time-multiplexed (serial) FIR datapath: one shared multiplier-accumulator, one sample RAM and one coefficient ROM serve all gp_coeff_length taps over consecutive clocks.
- Accepts input samples over a valid/ready handshake and drives the sample-RAM write/read addresses, the coefficient address and the MAC controls.
- Flags taps whose history is not yet filled and pulses output-valid once the external MAC pipeline has drained.

---
 rtl/filt_fir_seq_ctrl_if.sv | 32 +++
 rtl/filt_fir_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_filt_fir_seq_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/filt_fir_seq_ctrl_if.sv
// Bundle of sample handshake, RAM/ROM addressing and MAC control signals
// of the serial FIR scheduler.
interface filt_fir_seq_ctrl_if #(
  parameter int gp_addr_width = 5
);
  // A sample transfers on a rising edge where i_vld & o_rdy & i_ena. The source
  // holds the sample and i_vld until o_rdy is high. i_vld may drop without a transfer.
  logic                     i_vld;
  logic                     o_rdy;
  logic                     o_smp_wr_en;
  logic [gp_addr_width-1:0] o_smp_wr_addr;
  logic [gp_addr_width-1:0] o_smp_rd_addr;
  logic [gp_addr_width-1:0] o_coeff_addr;
  logic                     o_mac_en;
  logic                     o_mac_clr;
  logic                     o_mac_last;
  logic                     o_tap_zero;
  logic                     o_oup_vld;
  logic                     o_busy;

  modport master (
    output i_vld,
    input  o_rdy, o_smp_wr_en, o_smp_wr_addr, o_smp_rd_addr, o_coeff_addr,
    input  o_mac_en, o_mac_clr, o_mac_last, o_tap_zero, o_oup_vld, o_busy
  );

  modport slave (
    input  i_vld,
    output o_rdy, o_smp_wr_en, o_smp_wr_addr, o_smp_rd_addr, o_coeff_addr,
    output o_mac_en, o_mac_clr, o_mac_last, o_tap_zero, o_oup_vld, o_busy
  );
endinterface

// File: rtl/filt_fir_seq_ctrl.sv
// Tap scheduler for a serial FIR: one MAC, one sample RAM and one coefficient
// ROM are walked over N consecutive enabled cycles per accepted sample.
module filt_fir_seq_ctrl #(
  parameter int gp_coeff_length = 17,
  parameter int gp_symm         = 1,
  parameter int gp_mac_lat      = 2,
  parameter int gp_addr_width   = ($clog2(gp_coeff_length) > 1) ? $clog2(gp_coeff_length) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ena,
  filt_fir_seq_ctrl_if.slave bus,
  output logic [1:0]         o_dbg_state
);

  localparam int N   = gp_coeff_length;
  localparam int AW  = gp_addr_width;
  localparam int FCW = $clog2(N + 1);
  localparam int LW  = ($clog2(gp_mac_lat + 1) > 1) ? $clog2(gp_mac_lat + 1) : 1;

  localparam logic [AW-1:0]  K_LAST   = AW'(N - 1);
  localparam logic [AW-1:0]  K_HALF   = AW'((N + 1) / 2);
  localparam logic [AW:0]    N_EXT    = (AW + 1)'(N);
  localparam logic [FCW-1:0] FC_MAX   = FCW'(N);
  localparam logic [LW-1:0]  LAT_LAST = LW'(gp_mac_lat);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  k, k_nxt;
  logic [AW-1:0]  base, base_nxt;
  logic [AW-1:0]  wp, wp_nxt;
  logic [FCW-1:0] fc, fc_nxt;
  logic [LW-1:0]  lat_cnt, lat_nxt;

  logic           accept;
  logic           run_nxt;
  logic [AW:0]    rd_sum;
  logic [AW-1:0]  rd_nxt;
  logic [AW-1:0]  coeff_nxt;

  logic           mac_en_q, mac_clr_q, mac_last_q, tap_zero_q, oup_vld_q, busy_q;
  logic [AW-1:0]  rd_addr_q, coeff_addr_q;

  assign accept = (state == ST_IDLE) && bus.i_vld && i_ena;

  // Next-state and counter updates; everything holds while i_ena is low.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    base_nxt  = base;
    wp_nxt    = wp;
    fc_nxt    = fc;
    lat_nxt   = lat_cnt;
    if (i_ena) begin
      case (state)
        ST_IDLE: begin
          if (bus.i_vld) begin
            state_nxt = ST_RUN;
            k_nxt     = '0;
            base_nxt  = wp;
            wp_nxt    = (wp == K_LAST) ? '0 : wp + 1'b1;
            fc_nxt    = (fc == FC_MAX) ? fc : fc + 1'b1;
          end
        end
        ST_RUN: begin
          if (k == K_LAST) begin
            state_nxt = ST_DONE;
            lat_nxt   = '0;
          end else begin
            k_nxt = k + 1'b1;
          end
        end
        ST_DONE: begin
          if (lat_cnt == LAT_LAST) state_nxt = ST_IDLE;
          else                     lat_nxt   = lat_cnt + 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Tap-dependent outputs are computed from the next k so they register
  // into the very cycle that tap is presented.
  always_comb begin
    run_nxt = (state_nxt == ST_RUN);
    rd_sum  = {1'b0, base_nxt} + N_EXT - {1'b0, k_nxt};
    if (rd_sum >= N_EXT) rd_sum = rd_sum - N_EXT;
    rd_nxt  = rd_sum[AW-1:0];
    if ((gp_symm != 0) && (k_nxt >= K_HALF)) coeff_nxt = K_LAST - k_nxt;
    else                                     coeff_nxt = k_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      k       <= '0;
      base    <= '0;
      wp      <= '0;
      fc      <= '0;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      k       <= k_nxt;
      base    <= base_nxt;
      wp      <= wp_nxt;
      fc      <= fc_nxt;
      lat_cnt <= lat_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mac_en_q     <= 1'b0;
      mac_clr_q    <= 1'b0;
      mac_last_q   <= 1'b0;
      tap_zero_q   <= 1'b0;
      oup_vld_q    <= 1'b0;
      busy_q       <= 1'b0;
      rd_addr_q    <= '0;
      coeff_addr_q <= '0;
    end else if (i_ena) begin
      mac_en_q   <= run_nxt;
      mac_clr_q  <= run_nxt && (k_nxt == '0);
      mac_last_q <= run_nxt && (k_nxt == K_LAST);
      tap_zero_q <= run_nxt && (FCW'(k_nxt) >= fc_nxt);
      oup_vld_q  <= (state_nxt == ST_DONE) && (lat_nxt == LAT_LAST);
      busy_q     <= (state_nxt != ST_IDLE);
      if (run_nxt) begin
        rd_addr_q    <= rd_nxt;
        coeff_addr_q <= coeff_nxt;
      end
    end
  end

  // Strobes are masked by i_ena so a stalled cycle never counts as an operation.
  assign bus.o_rdy         = (state == ST_IDLE);
  assign bus.o_smp_wr_en   = accept;
  assign bus.o_smp_wr_addr = wp;
  assign bus.o_smp_rd_addr = rd_addr_q;
  assign bus.o_coeff_addr  = coeff_addr_q;
  assign bus.o_mac_en      = mac_en_q && i_ena;
  assign bus.o_mac_clr     = mac_clr_q;
  assign bus.o_mac_last    = mac_last_q;
  assign bus.o_tap_zero    = tap_zero_q;
  assign bus.o_oup_vld     = oup_vld_q && i_ena;
  assign bus.o_busy        = busy_q;
  assign o_dbg_state       = state;

endmodule

// File: tb/tb_filt_fir_seq_ctrl.sv
// Directed bench for filt_fir_seq_ctrl: N=17 symmetric/lat 2 and N=4 plain/lat 0.
module tb_filt_fir_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic ena;
  logic vld;
  logic sel_b;
  logic [1:0] st_a, st_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  filt_fir_seq_ctrl_if #(.gp_addr_width(5)) ifa ();
  filt_fir_seq_ctrl_if #(.gp_addr_width(2)) ifb ();

  assign ifa.i_vld = vld && !sel_b;
  assign ifb.i_vld = vld && sel_b;

  filt_fir_seq_ctrl #(
    .gp_coeff_length(17), .gp_symm(1), .gp_mac_lat(2), .gp_addr_width(5)
  ) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .bus(ifa.slave), .o_dbg_state(st_a)
  );

  filt_fir_seq_ctrl #(
    .gp_coeff_length(4), .gp_symm(0), .gp_mac_lat(0), .gp_addr_width(2)
  ) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .bus(ifb.slave), .o_dbg_state(st_b)
  );

  // Selected-DUT view so one set of driver tasks serves both instances
  logic       s_rdy, s_wr_en, s_mac_en, s_clr, s_last, s_tz, s_oup, s_busy;
  logic [4:0] s_wr_addr, s_rd, s_coeff;
  logic [1:0] s_state;

  always_comb begin
    if (sel_b) begin
      s_rdy = ifb.o_rdy;       s_wr_en = ifb.o_smp_wr_en; s_mac_en = ifb.o_mac_en;
      s_clr = ifb.o_mac_clr;   s_last = ifb.o_mac_last;   s_tz = ifb.o_tap_zero;
      s_oup = ifb.o_oup_vld;   s_busy = ifb.o_busy;       s_state = st_b;
      s_wr_addr = {3'b000, ifb.o_smp_wr_addr};
      s_rd      = {3'b000, ifb.o_smp_rd_addr};
      s_coeff   = {3'b000, ifb.o_coeff_addr};
    end else begin
      s_rdy = ifa.o_rdy;       s_wr_en = ifa.o_smp_wr_en; s_mac_en = ifa.o_mac_en;
      s_clr = ifa.o_mac_clr;   s_last = ifa.o_mac_last;   s_tz = ifa.o_tap_zero;
      s_oup = ifa.o_oup_vld;   s_busy = ifa.o_busy;       s_state = st_a;
      s_wr_addr = ifa.o_smp_wr_addr;
      s_rd      = ifa.o_smp_rd_addr;
      s_coeff   = ifa.o_coeff_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_rdy"},      s_rdy,     1);
    chk({pfx, "_wr_en"},    s_wr_en,   0);
    chk({pfx, "_wr_addr"},  s_wr_addr, 0);
    chk({pfx, "_rd_addr"},  s_rd,      0);
    chk({pfx, "_coeff"},    s_coeff,   0);
    chk({pfx, "_mac_en"},   s_mac_en,  0);
    chk({pfx, "_mac_clr"},  s_clr,     0);
    chk({pfx, "_mac_last"}, s_last,    0);
    chk({pfx, "_tap_zero"}, s_tz,      0);
    chk({pfx, "_oup_vld"},  s_oup,     0);
    chk({pfx, "_busy"},     s_busy,    0);
    chk({pfx, "_state"},    s_state,   0);
  endtask

  function automatic int coeff_of(input int n, input int symm, input int k);
    if (symm != 0 && k >= (n + 1) / 2) return n - 1 - k;
    return k;
  endfunction

  // One full sample: acceptance cycle, N taps, MAC drain, return to ready.
  task automatic do_sample(input int n, input int lat, input int symm,
                           input int wp_exp, input int fc_exp, input int stall_k);
    int waited, cyc, ce;
    logic got;
    logic [4:0] e;
    #1;
    waited = 0;
    while (!s_wr_en && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_wr_en", s_wr_en, 1);
    if (!s_wr_en) return;
    chk("accept_wr_addr", s_wr_addr, wp_exp);
    chk("accept_rdy", s_rdy, 1);
    for (int k = 0; k < n; k++) exp_q.push_back(5'((wp_exp - k + n) % n));
    cyc = 0;
    for (int k = 0; k < n; k++) begin
      e  = exp_q.pop_front();
      ce = coeff_of(n, symm, k);
      @(negedge clk);
      cyc++;
      chk("tap_mac_en",   s_mac_en, 1);
      chk("tap_rd_addr",  s_rd,     e);
      chk("tap_coeff",    s_coeff,  ce);
      chk("tap_mac_clr",  s_clr,    (k == 0));
      chk("tap_mac_last", s_last,   (k == n - 1));
      chk("tap_zero",     s_tz,     (k >= fc_exp));
      chk("tap_wr_en",    s_wr_en,  0);
      chk("tap_rdy",      s_rdy,    0);
      chk("tap_busy",     s_busy,   1);
      chk("tap_oup_vld",  s_oup,    0);
      if (k == stall_k) begin
        ena = 1'b0;
        repeat (3) begin
          @(negedge clk);
          cyc++;
          chk("stall_mac_en",  s_mac_en, 0);
          chk("stall_rd_addr", s_rd,     e);
          chk("stall_coeff",   s_coeff,  ce);
          chk("stall_oup_vld", s_oup,    0);
          chk("stall_state",   s_state,  1);
        end
        ena = 1'b1;
      end
    end
    got = 1'b0;
    for (int i = 0; i < lat + 4 && !got; i++) begin
      @(negedge clk);
      cyc++;
      chk("drain_wr_en",  s_wr_en,  0);
      chk("drain_mac_en", s_mac_en, 0);
      got = s_oup;
    end
    chk("oup_vld_seen", got, 1);
    chk("oup_vld_cycle", cyc, n + lat + 1 + ((stall_k >= 0) ? 3 : 0));
    @(negedge clk);
    chk("ready_after", s_rdy, 1);
    chk("oup_vld_pulse", s_oup, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ena = 1'b1; vld = 1'b0; sel_b = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst_a");
    rst = 1'b0;

    // Back-to-back samples with i_vld held high; a stall is planted at k=5
    vld = 1'b1;
    for (int i = 0; i < 18; i++)
      do_sample(17, 2, 1, i % 17, (i + 1 > 17) ? 17 : i + 1, (i == 2) ? 5 : -1);
    vld = 1'b0;

    // Reset mid-RUN aborts the sample without an output pulse
    @(negedge clk);
    vld = 1'b1;
    #1;
    chk("abort_accept", s_wr_en, 1);
    @(negedge clk);
    vld = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_running", s_state, 1);
    rst = 1'b1;
    #1;
    chk_reset_vals("abort_rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      chk("abort_no_oup", s_oup, 0);
    end
    vld = 1'b1;
    do_sample(17, 2, 1, 0, 1, -1);
    vld = 1'b0;

    // Small plain-coefficient instance, zero MAC latency
    @(negedge clk);
    sel_b = 1'b1;
    #1;
    chk_reset_vals("idle_b");
    vld = 1'b1;
    for (int i = 0; i < 6; i++)
      do_sample(4, 0, 0, i % 4, (i + 1 > 4) ? 4 : i + 1, -1);
    vld = 1'b0;
    @(negedge clk);
    chk("b_idle_end", s_state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
